// File: rtl/pwm_multicanal.sv
// Multi-channel PWM with one shared counter (edge- or center-aligned).
// Duty, period and mode are double-buffered and load only at period boundaries.
module pwm_multicanal #(
  parameter int WIDTH   = 22,
  parameter int CANALES = 4,
  parameter int SELW    = 2
) (
  input  logic               clk,
  input  logic               iniciar,
  input  logic               habilitar,
  input  logic               modo,
  input  logic [WIDTH-1:0]   periodo,
  input  logic               dato_wr,
  input  logic [SELW-1:0]    dato_canal,
  input  logic [WIDTH-1:0]   Dato,
  output logic [CANALES-1:0] pwm,
  output logic [WIDTH-1:0]   contador,
  output logic               fin_periodo
);

  // state | meaning
  // SUBE  | counter rising (always used in edge mode)
  // BAJA  | counter falling toward 1 (center mode only)
  typedef enum logic {SUBE = 1'b0, BAJA = 1'b1} dir_t;

  dir_t               dir_q, dir_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   per_act_q, per_act_d;
  logic               modo_act_q, modo_act_d;
  logic [WIDTH-1:0]   pend_q [CANALES];
  logic [WIDTH-1:0]   pend_d [CANALES];
  logic [WIDTH-1:0]   act_q  [CANALES];
  logic [WIDTH-1:0]   act_d  [CANALES];
  logic [CANALES-1:0] pwm_q, pwm_d;

  logic tope, bajando, limite, canal_ok;

  always_comb begin
    tope    = (cnt_q == per_act_q);
    // The top sample already belongs to the falling slope; with periodo_act=1
    // the top is also contador==1 and so closes a 2-cycle period.
    bajando = (dir_q == BAJA) || tope;
    if (per_act_q == '0)
      limite = 1'b1;
    else if (!modo_act_q)
      limite = tope;
    else
      limite = bajando && (cnt_q == WIDTH'(1));
  end

  assign canal_ok    = {1'b0, dato_canal} < (SELW+1)'(CANALES);
  assign fin_periodo = iniciar && habilitar && limite;

  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    per_act_d  = per_act_q;
    modo_act_d = modo_act_q;
    pend_d     = pend_q;
    act_d      = act_q;
    pwm_d      = '0;

    for (int i = 0; i < CANALES; i++)
      pwm_d[i] = habilitar && (cnt_q < act_q[i]);

    if (!habilitar || limite) begin
      cnt_d      = '0;
      dir_d      = SUBE;
      per_act_d  = periodo;
      modo_act_d = modo;
      act_d      = pend_q;
    end else if (!modo_act_q) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (bajando) begin
      dir_d = BAJA;
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    if (dato_wr && canal_ok)
      pend_d[dato_canal] = Dato;
  end

  always_ff @(posedge clk) begin
    if (!iniciar) begin
      cnt_q      <= '0;
      dir_q      <= SUBE;
      per_act_q  <= '0;
      modo_act_q <= 1'b0;
      pwm_q      <= '0;
      for (int i = 0; i < CANALES; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      per_act_q  <= per_act_d;
      modo_act_q <= modo_act_d;
      pwm_q      <= pwm_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
    end
  end

  assign pwm      = pwm_q;
  assign contador = cnt_q;

endmodule
